// File: rtl/wt_mem_ctrl.sv
// Memory-side controller for a write-through data cache: posted write buffer drained one beat at
// a time, plus line refill sequencing, sharing a single registered memory port.
module wt_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned WB_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [3:0]                    wr_strb,
  output logic                          wr_ready,
  input  logic                          refill_req,
  input  logic [ADDR_WIDTH-1:0]         refill_addr,
  output logic                          refill_wvalid,
  output logic [$clog2(LINE_WORDS)-1:0] refill_widx,
  output logic [DATA_WIDTH-1:0]         refill_wdata,
  output logic                          refill_done,
  output logic                          busy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [3:0]                    mem_wstrb,
  input  logic                          mem_ready,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam logic [BW-1:0] LastBeat = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LineMask = ~(ADDR_WIDTH'(LINE_WORDS * 4 - 1));
  localparam logic [PW:0] Depth = (PW + 1)'(WB_DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StRefill, StDone} state_e;

  state_e state_q, state_d;

  // Write buffer storage (data only, no reset needed)
  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic [3:0]            wb_strb_q [WB_DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q, nxt_idx;
  logic [PW:0]   count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          pending_q, pending_d;
  logic          push, pop;

  logic                  mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [3:0]            mem_wstrb_d;

  // Stores are held off while any refill is requested or in flight
  assign wr_ready = (count_q < Depth) && !pending_q && !refill_req &&
                    ((state_q == StIdle) || (state_q == StWrite));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == StWrite) && mem_req && mem_ready;
  assign nxt_idx  = rd_ptr_q + PW'(1);

  assign refill_widx  = beat_q;
  assign refill_wdata = refill_wvalid ? mem_rdata : '0;
  assign busy         = (state_q != StIdle) || (count_q != '0) || refill_req;

  // Buffer storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= wr_addr;
      wb_data_q[wr_ptr_q] <= wr_data;
      wb_strb_q[wr_ptr_q] <= wr_strb;
    end
  end

  // Occupancy update; push and pop together leave count unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state, memory port next values and refill beat strobes
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    pending_d     = pending_q;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    mem_wstrb_d   = mem_wstrb;
    refill_wvalid = 1'b0;
    refill_done   = 1'b0;

    if (refill_req && ((state_q == StIdle) || (state_q == StWrite))) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d     = StWrite;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr_q[rd_ptr_q];
          mem_wdata_d = wb_data_q[rd_ptr_q];
          mem_wstrb_d = wb_strb_q[rd_ptr_q];
        end else if (refill_req) begin
          state_d     = StRefill;
          pending_d   = 1'b0;
          beat_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = refill_addr & LineMask;
          mem_wdata_d = '0;
          mem_wstrb_d = 4'b0000;
        end
      end
      StWrite: begin
        if (mem_ready) begin
          if (count_q > (PW + 1)'(1)) begin
            mem_addr_d  = wb_addr_q[nxt_idx];
            mem_wdata_d = wb_data_q[nxt_idx];
            mem_wstrb_d = wb_strb_q[nxt_idx];
          end else if (push) begin
            // Buffer drains to the entry being pushed right now: forward it
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_wstrb_d = wr_strb;
          end else begin
            state_d     = StIdle;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_wstrb_d = 4'b0000;
          end
        end
      end
      StRefill: begin
        if (mem_ready) begin
          refill_wvalid = 1'b1;
          if (beat_q == LastBeat) begin
            state_d    = StDone;
            mem_req_d  = 1'b0;
            mem_addr_d = '0;
          end else begin
            beat_d     = beat_q + BW'(1);
            mem_addr_d = mem_addr + ADDR_WIDTH'(4);
          end
        end
      end
      StDone: begin
        refill_done = 1'b1;
        beat_d      = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered memory port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      beat_q    <= '0;
      pending_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= nxt_idx;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_wt_mem_ctrl.sv
// Bench for wt_mem_ctrl: directed scenarios plus random traffic, all scored by a transaction-level
// model (queue of accepted stores, expected refill beat, expected done pulse).
module tb_wt_mem_ctrl;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WB_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ready;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_wvalid;
  logic [1:0]  refill_widx;
  logic [31:0] refill_wdata;
  logic        refill_done;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  wt_mem_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LINE_WORDS(LINE_WORDS),
    .WB_DEPTH  (WB_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_ready     (wr_ready),
    .refill_req   (refill_req),
    .refill_addr  (refill_addr),
    .refill_wvalid(refill_wvalid),
    .refill_widx  (refill_widx),
    .refill_wdata (refill_wdata),
    .refill_done  (refill_done),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t wq[$];          // stores accepted but not yet written to memory
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  int  done_cnt = 0;
  int  beat_exp = 0;
  bit  done_exp = 0;
  bit  rand_rdata = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs were set after the previous edge; score at negedge, then cross the edge
  task automatic tick();
    bit          exp_rdy;
    bit          saw_done;
    wr_t         e;
    logic [31:0] base;
    mem_rdata = rand_rdata ? $urandom : 32'h11 * beat_exp;
    @(negedge clk);
    if (rst) begin
      @(posedge clk); #1;
      wq.delete();
      beat_exp = 0;
      done_exp = 0;
      return;
    end
    exp_rdy = (wq.size() < WB_DEPTH) && !refill_req;
    check_eq("wr_ready", wr_ready, exp_rdy);
    check_eq("busy", busy, (wq.size() != 0) || refill_req);
    check_eq("refill_done", refill_done, done_exp);
    saw_done = done_exp;
    if (done_exp) done_cnt++;
    done_exp = 0;
    if (mem_req && mem_ready && mem_we) begin
      check_eq("wr_qnonempty", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check_eq("wr_addr", mem_addr, e.a);
        check_eq("wr_data", mem_wdata, e.d);
        check_eq("wr_strb", mem_wstrb, e.s);
        wr_cnt++;
      end
      check_eq("rvalid_on_wr", refill_wvalid, 0);
    end else if (mem_req && mem_ready) begin
      base = refill_addr & ~32'(LINE_WORDS * 4 - 1);
      check_eq("rd_req_held", refill_req, 1);
      check_eq("rd_after_drain", wq.size(), 0);
      check_eq("rd_addr", mem_addr, base + 32'(4 * beat_exp));
      check_eq("rd_wstrb", mem_wstrb, 0);
      check_eq("rvalid", refill_wvalid, 1);
      check_eq("widx", refill_widx, beat_exp);
      check_eq("wdata", refill_wdata, mem_rdata);
      rd_cnt++;
      beat_exp++;
      if (beat_exp == LINE_WORDS) begin
        beat_exp = 0;
        done_exp = 1;
      end
    end else begin
      check_eq("rvalid_idle", refill_wvalid, 0);
    end
    if (wr_valid && exp_rdy) wq.push_back('{a: wr_addr, d: wr_data, s: wr_strb});
    @(posedge clk); #1;
    if (saw_done) refill_req = 0;  // cache drops its request on seeing done
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_valid = 0;
  endtask

  // mode 0: ready always, 1: every 2nd cycle, 2: random
  task automatic drain(input int budget, input int mode);
    int n = 0;
    while ((wq.size() != 0 || refill_req || done_exp) && n < budget) begin
      mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    mem_ready = 0;
    check_eq("drain_in_budget", (wq.size() == 0) && !refill_req, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, n;
    rst = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    refill_req = 0; refill_addr = 0; mem_ready = 0; mem_rdata = 0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 0;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_wstrb", mem_wstrb, 0);
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", refill_done, 0);

    // Three stores, memory always ready
    mem_ready = 1; w0 = wr_cnt;
    push(32'h100, 32'hAA, 4'hF);
    push(32'h104, 32'hBB, 4'b0011);
    push(32'h108, 32'hCC, 4'hF);
    drain(50, 0);
    check_eq("t1_writes", wr_cnt - w0, 3);

    // Fill to capacity, 5th push refused while one entry pops
    mem_ready = 0; w0 = wr_cnt;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'hD0 + 32'(i), 4'hF);
    check_eq("t2_full", wr_ready, 0);
    mem_ready = 1;
    push(32'h210, 32'hDEAD, 4'hF);
    mem_ready = 0;
    check_eq("t2_reopen", wr_ready, 1);
    check_eq("t2_one_pop", wr_cnt - w0, 1);
    drain(50, 0);
    check_eq("t2_writes", wr_cnt - w0, 4);

    // Refill, empty buffer, ready every 2nd cycle
    r0 = rd_cnt; d0 = done_cnt;
    refill_addr = 32'h2034; refill_req = 1;
    drain(60, 1);
    check_eq("t3_reads", rd_cnt - r0, 4);
    check_eq("t3_done", done_cnt - d0, 1);

    // Refill behind two buffered stores
    w0 = wr_cnt; r0 = rd_cnt;
    push(32'h300, 32'h1234, 4'b1100);
    push(32'h304, 32'h5678, 4'b0001);
    refill_addr = 32'h3008; refill_req = 1;
    drain(60, 0);
    check_eq("t4_writes", wr_cnt - w0, 2);
    check_eq("t4_reads", rd_cnt - r0, 4);

    // Reset during refill beat 2
    refill_addr = 32'h4008; refill_req = 1; mem_ready = 1; n = 0;
    while (beat_exp != 2 && n < 20) begin tick(); n++; end
    mem_ready = 0;
    check_eq("t5_req_hi", mem_req, 1);
    rst = 1; refill_req = 0;
    tick();
    rst = 0;
    check_eq("t5_req_drop", mem_req, 0);
    d0 = done_cnt;
    repeat (5) tick();
    check_eq("t5_no_done", done_cnt - d0, 0);
    r0 = rd_cnt; d0 = done_cnt;
    refill_req = 1;
    drain(60, 2);
    check_eq("t5_reads", rd_cnt - r0, 4);
    check_eq("t5_done", done_cnt - d0, 1);

    // Six back-to-back pushes with concurrent pops (pointer wrap)
    mem_ready = 1; w0 = wr_cnt;
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(4 * i), 32'hE0 + 32'(i), 4'(i + 1));
    drain(50, 0);
    check_eq("t6_writes", wr_cnt - w0, 6);

    // Random traffic
    rand_rdata = 1;
    for (int i = 0; i < 500; i++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = $urandom & 32'hFFFF_FFFC;
      wr_data   = $urandom;
      wr_strb   = 4'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      if (!refill_req && $urandom_range(0, 19) == 0) begin
        refill_addr = $urandom;
        refill_req  = 1;
      end
      tick();
    end
    wr_valid = 0;
    drain(300, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wt_mem_ctrl.md
Name: wt_mem_ctrl

Overview:
- Memory-side controller behind the write-through data cache.
- Holds store write-throughs in a small posted write buffer and drains them to main memory one beat at a time.
- Sequences line refills on cache read misses as a burst of single-word reads.
- Arbitrates the single main-memory port between buffer drain and refill; a refill never overtakes a buffered store.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- LINE_WORDS, 4, words per cache line (power of 2, ≥2)
- WB_DEPTH, 4, write buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  cache presents a write-through
- wr_addr  in  ADDR_WIDTH  store byte address (word-aligned)
- wr_data  in  DATA_WIDTH  store data, already lane-aligned
- wr_strb  in  4  byte enables
- wr_ready  out  1  buffer accepts a push this cycle
- refill_req  in  1  level request, held until refill_done
- refill_addr  in  ADDR_WIDTH  miss address, held with refill_req
- refill_wvalid  out  1  one refill word valid this cycle
- refill_widx  out  log2(LINE_WORDS)  word index within the line
- refill_wdata  out  DATA_WIDTH  refill word
- refill_done  out  1  one-cycle pulse, line complete
- busy  out  1  refill pending/active or buffer non-empty
- mem_req  out  1  memory transaction request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  write data
- mem_wstrb  out  4  write byte enables; 4'b0000 on reads
- mem_ready  in  1  memory completes the presented transaction this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ready on reads

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FSM→IDLE, buffer empty (count=0), beat counter=0. All outputs 0 except wr_ready=1 from the first cycle after reset. Applies mid-transaction: mem_req drops; memory side discards the abandoned transaction; buffered data lost.
- Memory handshake: mem_req and all mem_* fields registered, held stable until the cycle mem_ready=1. Transfer completes in that cycle. mem_ready while mem_req=0 is ignored.
- Write buffer: circular FIFO, WB_DEPTH entries {addr, data, strb}.
  - Push when wr_valid && wr_ready.
  - wr_ready = (count<WB_DEPTH) && !refill_pending && state!=REFILL.
  - At full, push is refused even if a pop occurs the same cycle.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo WB_DEPTH.
  - A pushed entry is first presented on mem_* no earlier than the next cycle.
- refill_pending: set when refill_req=1 in IDLE/WRITE, cleared on entering REFILL.
- FSM:
  - IDLE:
    - count>0 → WRITE; next cycle mem_req=1, mem_we=1 with the head entry.
    - Else refill_req → REFILL; next cycle mem_req=1, mem_we=0, mem_addr=line base, beat=0.
    - Line base = refill_addr with low log2(LINE_WORDS)+2 bits cleared.
  - WRITE: on mem_ready, pop head.
    - If count after pop >0 → stay WRITE; next entry presented next cycle.
    - Else → IDLE.
    - A pending refill therefore waits for a full drain.
  - REFILL, beat i: mem_addr = base + 4*i. On mem_ready:
    - Same cycle: refill_wvalid=1, refill_widx=i, refill_wdata=mem_rdata (combinational pass-through).
    - If i<LINE_WORDS-1: beat=i+1, next address presented next cycle.
    - Else → DONE.
  - DONE: refill_done=1 for one cycle, mem_req=0 → IDLE.
    - refill_req sampled in IDLE after DONE is treated as a new request.
    - The cache drops refill_req on seeing refill_done.
- busy = (state!=IDLE) || count>0 || refill_req.
- Address arithmetic is modulo 2^ADDR_WIDTH; no line crosses a wrap, since the base is aligned.
- refill_req with count=0 and wr_valid in the same IDLE cycle: the push is refused (wr_ready=0 combinationally from refill_req) and the refill starts.

Test Plan:
- Reset then push 3 stores (0x100/0xAA, 0x104/0xBB strb 4'b0011, 0x108/0xCC), mem_ready always 1 → three mem writes in push order, addresses/data/strb exact; busy falls the cycle after the last ready.
- Push 4 stores with mem_ready=0 → wr_ready=0 after the 4th. Push 5th with mem_ready pulsed the same cycle → 5th refused; one pop; wr_ready=1 the next cycle.
- Refill_req addr 0x2034 with empty buffer, mem_ready=1 every 2nd cycle, rdata=0x11·i → reads 0x2030, 0x2034, 0x2038, 0x203C in order. refill_widx 0..3 with matching data; refill_done pulses once, one cycle after the beat-3 ready.
- Two stores buffered, then refill_req → both writes complete before the first read; wr_ready=0 from refill_req until IDLE after DONE.
- rst asserted during refill beat 2 with mem_req high → next cycle mem_req=0, refill_done never pulses. Fresh refill_req afterwards restarts at beat 0.
- Push 6 stores back-to-back with a simultaneous pop each cycle (mem_ready=1) → pointers wrap; memory sees all 6 in order with no duplicates.
